// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse_meter block.
package pulse_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEASURE  = 2'd2,
    REPORT   = 2'd3
  } pm_state_e;

  // Consecutive synchronized cycles needed before the filtered sample changes
  localparam int FILT_LEN = 4;

  // Saturation value of the lost-pulse counter
  localparam int MISSED_MAX = 255;

endpackage

// File: rtl/pulse_sync_filter.sv
// Input synchronizer for pulse_meter with an optional glitch filter.
// Define PULSE_METER_GLITCH_FILTER_EN to enable the filter: the sample then
// changes only after the synchronized level is stable for FILT_LEN cycles,
// delaying both edges by FILT_LEN-1 cycles.
// 'settled' goes high once every flop feeding the sample holds real input
// data rather than reset zeros.
module pulse_sync_filter
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_Pulse,
  input  logic rst_n,
  input  logic pulse_in,
  output logic sample,
  output logic settled
);

`ifdef PULSE_METER_GLITCH_FILTER_EN
  localparam int SETTLE_LEN = SYNC_STAGES + FILT_LEN - 1;
`else
  localparam int SETTLE_LEN = SYNC_STAGES;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SETTLE_LEN-1:0]  settle_q;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign settled  = settle_q[SETTLE_LEN-1];

  // Synchronizer chain and settle tracker (a 1 marches through after reset)
  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      settle_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      settle_q <= {settle_q[SETTLE_LEN-2:0], 1'b1};
    end
  end

`ifdef PULSE_METER_GLITCH_FILTER_EN
  logic [FILT_LEN-2:0] hist_q;
  logic                filt_q;
  logic [FILT_LEN-1:0] window;

  assign window = {hist_q, sync_lvl};

  // Filtered level: follow the window when it is unanimous, otherwise hold
  always_comb begin
    sample = filt_q;
    if (&window) begin
      sample = 1'b1;
    end else if (~|window) begin
      sample = 1'b0;
    end
  end

  // History of recent synchronized levels and the held filter output
  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= window[FILT_LEN-2:0];
      filt_q <= sample;
    end
  end
`else
  assign sample = sync_lvl;
`endif

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures the width (in clk_Pulse cycles) of an asynchronous
// active-high pulse, compares it with duration +/- tol and hands the result
// out over a valid/ready interface. Pulses that arrive while a result is
// still pending are counted in 'missed' and dropped.
// Optional glitch filter: define PULSE_METER_GLITCH_FILTER_EN.
module pulse_meter
  import pulse_pkg::*;
#(
  parameter int CNT_W       = 30,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_Pulse,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic [7:0]       duration,
  input  logic [3:0]       tol,
  input  logic             w_ready,
  output logic             w_valid,
  output logic [CNT_W-1:0] w_width,
  output logic             w_ovf,
  output logic             w_match,
  output logic [7:0]       missed,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Wide enough for both operands so narrow CNT_W builds do not truncate duration
  localparam int CMP_W = (CNT_W + 1 > 9) ? CNT_W + 1 : 9;

  pm_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_ovf;
  logic             samp_q;
  logic             sample;
  logic             settled;
  logic             rise;
  logic             accept;

  function automatic logic [7:0] sat_inc_missed(input logic [7:0] v);
    return (v == 8'(MISSED_MAX)) ? v : v + 8'd1;
  endfunction

  function automatic logic within_tol(input logic [CNT_W-1:0] w,
                                      input logic [7:0]       d,
                                      input logic [3:0]       t);
    logic [CMP_W-1:0] wx, dx, tx, diff;
    wx   = CMP_W'(w);
    dx   = CMP_W'(d);
    tx   = CMP_W'(t);
    diff = (wx >= dx) ? (wx - dx) : (dx - wx);
    return diff <= tx;
  endfunction

  pulse_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_Pulse (clk_Pulse),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .sample    (sample),
    .settled   (settled)
  );

  assign rise   = sample & ~samp_q;
  assign accept = w_valid & w_ready;

  // Measurement FSM with counter, result registers and lost-pulse counter
  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_LOW;
      cnt     <= '0;
      cnt_ovf <= 1'b0;
      samp_q  <= 1'b0;
      w_valid <= 1'b0;
      w_width <= '0;
      w_ovf   <= 1'b0;
      w_match <= 1'b0;
      missed  <= '0;
      busy    <= 1'b0;
    end else begin
      samp_q <= sample;
      unique case (state)
        WAIT_LOW: begin
          if (settled && !sample) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (sample) begin
            state   <= MEASURE;
            cnt     <= CNT_W'(1);
            cnt_ovf <= 1'b0;
            busy    <= 1'b1;
          end
        end
        MEASURE: begin
          if (sample) begin
            if (cnt == CNT_MAX) begin
              cnt_ovf <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            state   <= REPORT;
            busy    <= 1'b0;
            w_width <= cnt;
            w_ovf   <= cnt_ovf;
            w_match <= !cnt_ovf && within_tol(cnt, duration, tol);
          end
        end
        REPORT: begin
          if (rise && !accept) begin
            missed <= sat_inc_missed(missed);
          end
          if (!w_valid) begin
            w_valid <= 1'b1;
          end else if (w_ready) begin
            w_valid <= 1'b0;
            if (rise) begin
              state   <= MEASURE;
              cnt     <= CNT_W'(1);
              cnt_ovf <= 1'b0;
              busy    <= 1'b1;
            end else if (sample) begin
              // Tail of a pulse already counted as missed: skip it entirely
              state <= WAIT_LOW;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule
